// File: rtl/jt51_dac_ser_if.sv
// rtl/jt51_dac_ser_if.sv - sample input and serial DAC output bundle for jt51_dac_ser
//
// Signals:
//   cen        clock enable; one serial bit per cen pulse
//   sample_stb sample-valid strobe, qualified by cen
//   left/right signed 16-bit exact stereo sample, valid with sample_stb
//   so         serial data out
//   sh1/sh2    left/right word load strobes
//   busy       frame in progress
//   overrun    sticky overwrite indicator
//
// Modports: master drives samples and observes the serial side (core or bench),
//           slave is the serializer itself.

interface jt51_dac_ser_if;
  logic        cen;
  logic        sample_stb;
  logic [15:0] left;
  logic [15:0] right;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic        busy;
  logic        overrun;

  modport master (
    output cen, sample_stb, left, right,
    input  so, sh1, sh2, busy, overrun
  );

  modport slave (
    input  cen, sample_stb, left, right,
    output so, sh1, sh2, busy, overrun
  );
endinterface

// File: rtl/jt51_dac_ser.sv
// rtl/jt51_dac_ser.sv - YM3012-style floating-point serializer for exact stereo samples
//
// Each stereo pair is compressed per channel to a 10-bit two's complement
// mantissa plus a 3-bit exponent (1..7), then shifted out LSB first on a single
// data line: LEAD_ZEROS zeros, man[0..9], exp[0..2] for left, then the same for
// right. sh1 marks the last left bit, sh2 the last right bit.
//
// Build option: define JT51_DAC_ROUND_EN for round-half-up mantissas (with
// saturation to 511 at exponent 7); otherwise mantissas are truncated.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    jt51_dac_ser_if.slave: cen, sample_stb, left, right in;
//          so, sh1, sh2, busy, overrun out

module jt51_dac_ser #(
  parameter int LEAD_ZEROS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  jt51_dac_ser_if.slave bus
);

  localparam int W  = LEAD_ZEROS + 13;
  localparam int F  = 2 * W;
  localparam int CW = $clog2(F);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Returns {exp[2:0], man[9:0]} for one channel.
  function automatic logic [12:0] to_float(input logic [15:0] x);
    logic signed [16:0] xe;
    logic signed [16:0] v;
    logic [2:0]         e_sel;
    logic [9:0]         m_sel;
    logic               found;
    xe    = {x[15], x};
    e_sel = 3'd7;
    m_sel = 10'd511;   // only survives when rounding overflows at exp 7
    found = 1'b0;
    for (int e = 1; e <= 7; e++) begin
`ifdef JT51_DAC_ROUND_EN
      if (e == 1) begin
        v = xe;
      end else begin
        v = (xe + (17'sd1 <<< (e - 2))) >>> (e - 1);
      end
`else
      v = xe >>> (e - 1);
`endif
      if (!found && (v >= -17'sd512) && (v <= 17'sd511)) begin
        found = 1'b1;
        e_sel = 3'(e);
        m_sel = v[9:0];
      end
    end
    return {e_sel, m_sel};
  endfunction

  state_t        state_q;
  logic [F-1:0]  hold_q;
  logic [F-1:0]  sr_q;
  logic          pend_q;
  logic [CW-1:0] cnt_q;
  logic          so_q;
  logic          sh1_q;
  logic          sh2_q;
  logic          busy_q;
  logic          ovr_q;

  logic [12:0]   cvt_l;
  logic [12:0]   cvt_r;
  logic [F-1:0]  frame_new;
  logic [F-1:0]  load_frame_d;
  logic          at_end;
  logic          load_now;

  always_comb begin
    cvt_l = to_float(bus.left);
    cvt_r = to_float(bus.right);
  end

  // Frame is shifted out from bit 0, so each word sits as {exp, man, zeros}.
  assign frame_new = {cvt_r, {LEAD_ZEROS{1'b0}}, cvt_l, {LEAD_ZEROS{1'b0}}};

  assign at_end = (state_q == SHIFT) && (cnt_q == CW'(F - 1));

  // A load happens from IDLE or at the last frame bit whenever a sample is
  // available, either pending or arriving in this very cycle.
  assign load_now = bus.cen && ((state_q == IDLE) || at_end) &&
                    (pend_q || bus.sample_stb);

  // A pending sample is older than a coincident strobe, so it goes first.
  assign load_frame_d = pend_q ? hold_q : frame_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sr_q    <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      sh1_q   <= 1'b0;
      sh2_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (bus.cen) begin
      // Holding register: a strobe goes straight to the shifter only when
      // nothing older is waiting; otherwise it is parked.
      if (bus.sample_stb && !(load_now && !pend_q)) begin
        hold_q <= frame_new;
        pend_q <= 1'b1;
        if (pend_q && !load_now) begin
          ovr_q <= 1'b1;
        end
      end else if (load_now) begin
        pend_q <= 1'b0;
      end

      if (load_now) begin
        state_q <= SHIFT;
        sr_q    <= load_frame_d >> 1;
        so_q    <= load_frame_d[0];
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        sh1_q   <= 1'b0;
        sh2_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            so_q   <= 1'b0;
            sh1_q  <= 1'b0;
            sh2_q  <= 1'b0;
            busy_q <= 1'b0;
          end
          SHIFT: begin
            if (at_end) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              so_q    <= 1'b0;
              sh1_q   <= 1'b0;
              sh2_q   <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              so_q  <= sr_q[0];
              sr_q  <= sr_q >> 1;
              // Strobes are registered alongside the bit they mark.
              sh1_q <= (cnt_q == CW'(W - 2));
              sh2_q <= (cnt_q == CW'(F - 2));
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.so      = so_q;
  assign bus.sh1     = sh1_q;
  assign bus.sh2     = sh2_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_jt51_dac_ser.sv
// tb/tb_jt51_dac_ser.sv - scoreboard bench for jt51_dac_ser

module tb_jt51_dac_ser;

  localparam int LZ = 3;
  localparam int W  = LZ + 13;
  localparam int F  = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt51_dac_ser_if bus();

  jt51_dac_ser #(.LEAD_ZEROS(LZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [F-1:0] exp_q[$];
  logic [F-1:0] cur_frame = '0;
  logic [F-1:0] last_frame = '0;
  int           bit_idx = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference word: exponent from range bounds, word assembled bit by bit.
  function automatic logic [W-1:0] model_word(input logic [15:0] xin);
    int x;
    int e;
    int m;
    int v;
    logic [W-1:0] w;
    x = int'($signed(xin));
    e = 7;
    m = 511;
`ifdef JT51_DAC_ROUND_EN
    for (int k = 1; k <= 7; k++) begin
      v = (2 * x + (1 << (k - 1))) >>> k;
      if (v >= -512 && v <= 511) begin
        e = k;
        m = v;
        break;
      end
    end
`else
    for (int k = 1; k <= 7; k++) begin
      if (x >= -(512 << (k - 1)) && x < (512 << (k - 1))) begin
        e = k;
        m = x >>> (k - 1);
        break;
      end
    end
    v = m;
`endif
    w = '0;
    for (int i = 0; i < 10; i++) w[LZ + i] = m[i];
    for (int j = 0; j < 3; j++) w[LZ + 10 + j] = e[j];
    return w;
  endfunction

  function automatic logic [F-1:0] model_frame(input logic [15:0] l, input logic [15:0] r);
    return {model_word(r), model_word(l)};
  endfunction

  task automatic monitor();
    if (bus.busy) begin
      cur_frame[bit_idx] = bus.so;
      check("sh1", bus.sh1, (bit_idx == W - 1));
      check("sh2", bus.sh2, (bit_idx == F - 1));
      if (bit_idx == F - 1) begin
        last_frame = cur_frame;
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("frame", cur_frame, exp_q.pop_front());
        bit_idx = 0;
      end else begin
        bit_idx++;
      end
    end else begin
      check("idle_outs", {bus.so, bus.sh1, bus.sh2}, 3'b000);
      if (bit_idx != 0) check("frame_cut", bit_idx, 0);
      bit_idx = 0;
    end
  endtask

  // One cen pulse (two clocks per cen), outputs sampled on the falling edge.
  task automatic tick(input bit stb, input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    bus.cen        = 1'b1;
    bus.sample_stb = stb;
    bus.left       = l;
    bus.right      = r;
    @(negedge clk);
    bus.cen        = 1'b0;
    bus.sample_stb = 1'b0;
    monitor();
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back(model_frame(l, r));
    tick(1'b1, l, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && bus.busy; i++) tick(1'b0, 16'h0, 16'h0);
    check("drain_busy", bus.busy, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  logic [15:0] rl;
  logic [15:0] rr;

  initial begin
    bus.cen        = 1'b0;
    bus.sample_stb = 1'b0;
    bus.left       = '0;
    bus.right      = '0;
    repeat (3) @(negedge clk);
    check("rst_so", bus.so, 0);
    check("rst_sh1", bus.sh1, 0);
    check("rst_sh2", bus.sh2, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 16'h0, 16'h0);

    // Small mantissas, exponent 1
    send(16'h0123, 16'hFE00);
    drain();
    check("t2_left_word", last_frame[15:0], 16'h2918);
    check("t2_right_word", last_frame[31:16], 16'h3000);

    // Full scale, exponent 7
    send(16'h7FFF, 16'h8000);
    drain();
    check("t3_left_word", last_frame[15:0], 16'hEFF8);
    check("t3_right_word", last_frame[31:16], 16'hF000);

    // Truncation vs rounding
    send(16'd1001, 16'h0000);
    drain();
`ifdef JT51_DAC_ROUND_EN
    check("t4_1001_word", last_frame[15:0], 16'h4FA8);
`else
    check("t4_1001_word", last_frame[15:0], 16'h4FA0);
`endif
    check("t4_zero_word", last_frame[31:16], 16'h2000);
    send(16'd32767, 16'h0000);
    drain();
    check("t4_sat_word", last_frame[15:0], 16'hEFF8);

    // Back-to-back frames at the 32-cen sample period
    send(16'h0100, 16'hFF00);
    for (int k = 1; k < 4 * F; k++) begin
      if (k % F == 0) send(16'(k * 37), 16'(-k * 91));
      else tick(1'b0, 16'h0, 16'h0);
      check("t5_busy_cont", bus.busy, 1);
    end
    drain();
    check("t5_overrun", bus.overrun, 0);

    // Strobes faster than a frame: second sample lost, third follows first
    for (int k = 0; k < 10; k++) begin
      if (k == 0) send(16'h1111, 16'h2222);
      else if (k == 5) tick(1'b1, 16'h3333, 16'h4444);
      else if (k == 9) send(16'hC555, 16'h0666);
      else tick(1'b0, 16'h0, 16'h0);
    end
    check("t6_overrun_set", bus.overrun, 1);
    drain();
    check("t6_overrun_sticky", bus.overrun, 1);

    // Edge values and random samples, spaced one frame apart
    send(16'hFDFF, 16'h0200);
    repeat (F + 2) tick(1'b0, 16'h0, 16'h0);
    send(16'hFFFF, 16'h0001);
    repeat (F + 2) tick(1'b0, 16'h0, 16'h0);
    send(16'h8001, 16'h4000);
    repeat (F + 2) tick(1'b0, 16'h0, 16'h0);
    for (int n = 0; n < 6; n++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      send(rl, rr);
      repeat (F + 2) tick(1'b0, 16'h0, 16'h0);
    end
    drain();

    // Asynchronous reset at bit 10 of a frame
    send(16'h7FFF, 16'hFFFF);
    repeat (10) tick(1'b0, 16'h0, 16'h0);
    check("t1_busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_so", bus.so, 0);
    check("t1_sh1", bus.sh1, 0);
    check("t1_sh2", bus.sh2, 0);
    check("t1_busy", bus.busy, 0);
    check("t1_overrun", bus.overrun, 0);
    exp_q.delete();
    bit_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 16'h0, 16'h0);
      check("t1_idle_after", bus.busy, 0);
    end
    send(16'h0055, 16'hFAAA);
    drain();
    check("t1_overrun_after", bus.overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jt51_dac_ser.md
Name: jt51_dac_ser

Overview:
- Downstream of the operator accumulator stage.
- Takes each exact stereo sample pair (16-bit signed, produced once per sample period on the accumulator's c1 strobe) and compresses each channel to a 10-bit mantissa plus 3-bit exponent floating word.
- Shifts the words out serially, YM3012-style, on a single data line with per-channel load strobes, so the core can drive an external floating-point DAC or a bit-exact capture bench.

Parameters:
- LEAD_ZEROS, 3: zero padding bits sent before each channel's 13 data bits. Word length W = LEAD_ZEROS+13; frame length F = 2*W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active low
- cen  input  1  clock enable; one serial bit per cen pulse; all state advances only when cen=1
- sample_stb  input  1  sample-valid strobe, qualified by cen (driven from c1_enters)
- left  input  16  signed exact left sample, valid when sample_stb=1
- right  input  16  signed exact right sample, valid when sample_stb=1
- so  output  1  serial data
- sh1  output  1  left-word load strobe
- sh2  output  1  right-word load strobe
- busy  output  1  frame in progress
- overrun  output  1  sticky: a pending sample was overwritten before use

Behaviour:
- Reset values: so=0, sh1=0, sh2=0, busy=0, overrun=0. Holding and shift registers are cleared, the pending flag is cleared, and the FSM is IDLE. Reset is asynchronous and may abort a frame mid-shift; outputs go to reset values immediately.
- Capture:
  - On cen & sample_stb, left and right are converted combinationally and latched into a holding register; pend is set.
  - If pend is already 1 and the FSM has not loaded the pending sample this cycle, the old pending sample is overwritten and overrun is set. overrun clears only on reset.
- Conversion, per channel, from signed 16-bit x:
  - exp = smallest e in 1..7 such that x>>>(e-1) fits in signed 10 bits (-512..511).
  - man = x>>>(exp-1), arithmetic shift, truncated.
  - Examples: -512..511 gives exp 1; -32768..32767 always resolves by exp 7.
- FSM states:
  - IDLE: busy=0, so=0. On cen with pend=1 (including a strobe in the same cycle), load the shift register from the holding register, clear pend, set bit counter to 0, go to SHIFT. Load to first bit out is 1 cen cycle.
  - SHIFT: one bit per cen.
    - Left word: LEAD_ZEROS zeros, then man[0..9] LSB first, then exp[0..2] LSB first.
    - Right word: same format.
    - sh1=1 during the last bit of the left word (counter = W-1). sh2=1 during the last bit of the right word (counter = F-1).
    - After bit F-1: if pend=1, reload and continue back-to-back with no gap bit; otherwise go to IDLE.
- Simultaneous strobe and reload in the same cen cycle: the new sample is loaded directly, pend stays 0, and no overrun is flagged.
- Timing: with the standard 32-cen sample period and LEAD_ZEROS=3, F=32. Frames run back-to-back and overrun never sets.
- Width rules: counter is clog2(F) bits and wraps only via the reload path. Mantissa is two's complement 10 bits; exponent is unsigned 3 bits, never 0.

Optional Feature:
- Macro: JT51_DAC_ROUND_EN.
- Defined: man = round-half-up of x/2^(exp-1), i.e. (x + 2^(exp-2))>>>(exp-1) for exp>1. Exponent selection uses the rounded value. A rounded result exceeding 511 at exp 7 saturates to 511.
- Undefined: truncation as in Behaviour.
- Serial format and timing are identical in both builds.

Test Plan:
1. Reset mid-frame: assert rst_n=0 at bit 10 of a frame -> so, sh1, sh2, busy, overrun are all 0 asynchronously; after release, FSM is IDLE until the next strobe.
2. left=0x0123, right=0xFE00 -> left word = 000, man 0x123 LSB first, exp 001; right word = 000, man 0x200, exp 001. sh1 at bit 15, sh2 at bit 31.
3. left=0x7FFF, right=0x8000 -> left exp=7, man=511; right exp=7, man=-512 (0x200).
4. left=1001: truncating build -> exp=2, man=500; with JT51_DAC_ROUND_EN -> man=501. left=32767 with rounding -> exp=7, man=511 (saturated).
5. Strobes every 32 cen for 4 samples -> four contiguous frames, busy continuously 1, overrun stays 0, no gap bits.
6. Strobes at cen 0, 5, 9 (faster than a frame) -> the first sample is shifted, the second is overwritten by the third, overrun=1, and the next frame carries the third sample.
